// File: rtl/spi_master_byte.sv
// rtl/spi_master_byte.sv - SPI mode-0 master, one C_bits word per tx_valid/tx_ready handshake
// All SPI pins are registered; rx_data is presented with a one-cycle rx_valid in DONE.
module spi_master_byte #(
  parameter int C_clk_div = 2,
  parameter int C_bits    = 8
) (
  input  logic              clk_25mhz,
  input  logic              reset,
  input  logic [C_bits-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [C_bits-1:0] rx_data,
  output logic              rx_valid,
  output logic              spi_csn,
  output logic              spi_clk,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  localparam int PH_W  = (C_clk_div > 1) ? $clog2(C_clk_div) : 1;
  localparam int BIT_W = $clog2(C_bits + 1);
  localparam logic [PH_W-1:0]  PH_LAST = PH_W'(C_clk_div - 1);
  localparam logic [BIT_W-1:0] BIT_ALL = BIT_W'(C_bits);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_LOW,
    S_DONE
  } state_t;

  state_t             state, state_n;
  logic [PH_W-1:0]    phase, phase_n;
  logic [BIT_W-1:0]   bit_cnt, bit_cnt_n;
  logic [C_bits-2:0]  tx_shift, tx_shift_n;
  logic [C_bits-1:0]  rx_shift, rx_shift_n;
  logic [C_bits-1:0]  rx_data_n;
  logic               rx_valid_n;
  logic               spi_csn_n;
  logic               spi_clk_n;
  logic               spi_mosi_n;
  logic               last_phase;

  assign tx_ready   = (state == S_IDLE) && !reset;
  assign last_phase = (phase == PH_LAST);

  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      state    <= S_IDLE;
      phase    <= '0;
      bit_cnt  <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      spi_csn  <= 1'b1;
      spi_clk  <= 1'b0;
      spi_mosi <= 1'b0;
    end else begin
      state    <= state_n;
      phase    <= phase_n;
      bit_cnt  <= bit_cnt_n;
      tx_shift <= tx_shift_n;
      rx_shift <= rx_shift_n;
      rx_data  <= rx_data_n;
      rx_valid <= rx_valid_n;
      spi_csn  <= spi_csn_n;
      spi_clk  <= spi_clk_n;
      spi_mosi <= spi_mosi_n;
    end
  end

  always_comb begin
    state_n    = state;
    phase_n    = phase;
    bit_cnt_n  = bit_cnt;
    tx_shift_n = tx_shift;
    rx_shift_n = rx_shift;
    rx_data_n  = rx_data;
    rx_valid_n = 1'b0;
    spi_csn_n  = spi_csn;
    spi_clk_n  = spi_clk;
    spi_mosi_n = spi_mosi;

    case (state)
      S_IDLE: begin
        spi_csn_n = 1'b1;
        spi_clk_n = 1'b0;
        if (tx_valid) begin
          state_n    = S_SETUP;
          phase_n    = '0;
          bit_cnt_n  = '0;
          tx_shift_n = tx_data[C_bits-2:0];
          spi_csn_n  = 1'b0;
          spi_mosi_n = tx_data[C_bits-1];
        end
      end

      // SETUP and LOW both end by raising SCLK, except the final LOW (CS hold).
      S_SETUP, S_LOW: begin
        if (last_phase) begin
          phase_n = '0;
          if (bit_cnt == BIT_ALL) begin
            state_n    = S_DONE;
            spi_csn_n  = 1'b1;
            spi_clk_n  = 1'b0;
            rx_valid_n = 1'b1;
            rx_data_n  = rx_shift;
          end else begin
            state_n    = S_HIGH;
            spi_clk_n  = 1'b1;
            rx_shift_n = {rx_shift[C_bits-2:0], spi_miso};
            bit_cnt_n  = bit_cnt + BIT_W'(1);
          end
        end else begin
          phase_n = phase + PH_W'(1);
        end
      end

      S_HIGH: begin
        if (last_phase) begin
          phase_n    = '0;
          state_n    = S_LOW;
          spi_clk_n  = 1'b0;
          spi_mosi_n = tx_shift[C_bits-2];
          tx_shift_n = tx_shift << 1;
        end else begin
          phase_n = phase + PH_W'(1);
        end
      end

      S_DONE: begin
        state_n = S_IDLE;
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_spi_master_byte.sv
// tb/tb_spi_master_byte.sv - directed bench for spi_master_byte (default and C_clk_div=1 instances)
// A mode-0 responder model drives MISO of the default instance; the other instance has MISO tied low.
module tb_spi_master_byte;

  typedef struct {
    logic [7:0] tx;
    logic [7:0] resp;
    int         pulse;
    logic [7:0] exp_rx;
    logic [7:0] exp_mosi;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] a_tx_data, a_rx_data, b_tx_data, b_rx_data;
  logic       a_tx_valid, a_tx_ready, a_rx_valid, a_spi_csn, a_spi_clk, a_spi_mosi, a_miso;
  logic       b_tx_valid, b_tx_ready, b_rx_valid, b_spi_csn, b_spi_clk, b_spi_mosi;

  logic [7:0] a_resp = 8'h00;
  logic [7:0] resp_lat = 8'h00;
  int         fall_cnt = 0;
  logic       prev_sclk = 1'b0;
  int         clk_bad = 0;
  int         checks = 0;
  int         failures = 0;
  vec_t       vecs[6];

  always #20 clk = ~clk;

  spi_master_byte #(.C_clk_div(2), .C_bits(8)) dut_a (
    .clk_25mhz(clk), .reset(reset), .tx_data(a_tx_data), .tx_valid(a_tx_valid),
    .tx_ready(a_tx_ready), .rx_data(a_rx_data), .rx_valid(a_rx_valid), .spi_csn(a_spi_csn),
    .spi_clk(a_spi_clk), .spi_mosi(a_spi_mosi), .spi_miso(a_miso)
  );

  spi_master_byte #(.C_clk_div(1), .C_bits(8)) dut_b (
    .clk_25mhz(clk), .reset(reset), .tx_data(b_tx_data), .tx_valid(b_tx_valid),
    .tx_ready(b_tx_ready), .rx_data(b_rx_data), .rx_valid(b_rx_valid), .spi_csn(b_spi_csn),
    .spi_clk(b_spi_clk), .spi_mosi(b_spi_mosi), .spi_miso(1'b0)
  );

  // Responder: reloads while CS is high, shifts after each SCLK fall.
  always @(negedge clk) begin
    if (a_spi_csn) begin
      resp_lat <= a_resp;
      fall_cnt <= 0;
    end else if (prev_sclk && !a_spi_clk) begin
      fall_cnt <= fall_cnt + 1;
    end
    prev_sclk <= a_spi_clk;
    if ((a_spi_csn && a_spi_clk) || (b_spi_csn && b_spi_clk)) clk_bad <= clk_bad + 1;
  end

  assign a_miso = (fall_cnt < 8) ? resp_lat[3'(7 - fall_cnt)] : 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_a(input vec_t v, input string tag);
    int rxv_cyc, rxv_cnt, csn_low, rises;
    logic [7:0] mosi_bits, rx_got;
    logic prev;
    rxv_cyc = 0; rxv_cnt = 0; csn_low = 0; rises = 0;
    mosi_bits = 8'h00; rx_got = 8'h00; prev = 1'b0;
    @(negedge clk);
    a_resp = v.resp;
    @(negedge clk);
    a_tx_data  = v.tx;
    a_tx_valid = 1'b1;
    check({tag, "_ready_idle"}, a_tx_ready, 1);
    for (int c = 1; c <= 44; c++) begin
      @(negedge clk);
      if (c == 1) begin
        a_tx_valid = 1'b0;
        a_tx_data  = ~v.tx;
      end
      if (v.pulse != 0 && c == v.pulse) a_tx_valid = 1'b1;
      if (v.pulse != 0 && c == v.pulse + 1) a_tx_valid = 1'b0;
      if (!a_spi_csn) csn_low++;
      if (a_spi_clk && !prev) begin
        rises++;
        mosi_bits = {mosi_bits[6:0], a_spi_mosi};
      end
      prev = a_spi_clk;
      if (a_rx_valid) begin
        rxv_cnt++;
        if (rxv_cnt == 1) begin
          rxv_cyc = c;
          rx_got  = a_rx_data;
          check({tag, "_ready_done"}, a_tx_ready, 0);
          check({tag, "_csn_done"}, a_spi_csn, 1);
        end
      end
    end
    check({tag, "_rx"}, rx_got, v.exp_rx);
    check({tag, "_mosi"}, mosi_bits, v.exp_mosi);
    check({tag, "_rises"}, rises, 8);
    check({tag, "_rxv_cyc"}, rxv_cyc, 35);
    check({tag, "_rxv_cnt"}, rxv_cnt, 1);
    check({tag, "_csn_low"}, csn_low, 34);
    check({tag, "_rx_hold"}, a_rx_data, v.exp_rx);
  endtask

  initial begin
    int k, gap, rises, csn_low, rxv_cyc, rxv_cnt, last_rise, per_bad;
    logic started, pend, prev;
    logic [7:0] exp_b, mosi_bits, rx_got;
    logic [6:0] btn;

    btn = 7'h55;
    vecs[0] = '{tx: 8'hA5, resp: 8'h3C, pulse: 0,  exp_rx: 8'h3C, exp_mosi: 8'hA5};
    vecs[1] = '{tx: 8'h00, resp: 8'hFF, pulse: 0,  exp_rx: 8'hFF, exp_mosi: 8'h00};
    vecs[2] = '{tx: 8'hFF, resp: 8'h00, pulse: 0,  exp_rx: 8'h00, exp_mosi: 8'hFF};
    vecs[3] = '{tx: 8'h81, resp: 8'h7E, pulse: 0,  exp_rx: 8'h7E, exp_mosi: 8'h81};
    vecs[4] = '{tx: 8'hC6, resp: 8'h35, pulse: 10, exp_rx: 8'h35, exp_mosi: 8'hC6};
    vecs[5] = '{tx: 8'h5A, resp: {1'b0, btn}, pulse: 0, exp_rx: 8'h55, exp_mosi: 8'h5A};

    reset = 1'b1;
    a_tx_data = 8'h00; a_tx_valid = 1'b0;
    b_tx_data = 8'h00; b_tx_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_csn", a_spi_csn, 1);
    check("rst_clk", a_spi_clk, 0);
    check("rst_mosi", a_spi_mosi, 0);
    check("rst_rxv", a_rx_valid, 0);
    check("rst_rxd", a_rx_data, 0);
    check("rst_ready", a_tx_ready, 0);
    check("rst_b_ready", b_tx_ready, 0);
    check("rst_b_csn", b_spi_csn, 1);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready", a_tx_ready, 1);

    for (int i = 0; i < 6; i++) run_a(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back with tx_valid held high; responder returns ~tx for each word.
    @(negedge clk);
    a_resp = ~8'h10;
    @(negedge clk);
    a_tx_data = 8'h10; a_tx_valid = 1'b1;
    k = 0; gap = 0; started = 1'b0; pend = 1'b1;
    for (int c = 0; c < 150 && k < 3; c++) begin
      @(negedge clk);
      if (pend) begin
        a_tx_data = a_tx_data + 8'h01;
        a_resp    = ~a_tx_data;
        pend      = 1'b0;
      end
      if (a_rx_valid) begin
        exp_b = ~(8'(8'h10 + k));
        check($sformatf("b2b_rx%0d", k), a_rx_data, exp_b);
        k++;
        if (k == 3) a_tx_valid = 1'b0;
      end
      if (a_tx_ready && a_tx_valid) pend = 1'b1;
      if (a_spi_csn) gap++;
      else begin
        if (started && gap != 0) check("b2b_gap", gap, 2);
        started = 1'b1;
        gap = 0;
      end
    end
    check("b2b_count", k, 3);
    repeat (2) @(negedge clk);
    check("b2b_idle_ready", a_tx_ready, 1);

    // Reset during the 4th SCLK high phase aborts the word.
    @(negedge clk);
    a_resp = 8'h99;
    @(negedge clk);
    a_tx_data = 8'h3C; a_tx_valid = 1'b1;
    rxv_cnt = 0; csn_low = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 1) a_tx_valid = 1'b0;
      if (c == 15) begin
        check("abort_in_high4", a_spi_clk, 1);
        reset = 1'b1;
      end
      if (c == 16) begin
        check("abort_csn", a_spi_csn, 1);
        check("abort_clk", a_spi_clk, 0);
        reset = 1'b0;
      end
      if (c >= 16 && !a_spi_csn) csn_low++;
      if (a_rx_valid) rxv_cnt++;
    end
    check("abort_no_rxv", rxv_cnt, 0);
    check("abort_csn_stays_high", csn_low, 0);
    run_a(vecs[0], "post_abort");

    // C_clk_div = 1 instance, MISO tied low.
    @(negedge clk);
    b_tx_data = 8'hFF; b_tx_valid = 1'b1;
    check("div1_ready", b_tx_ready, 1);
    rises = 0; csn_low = 0; rxv_cyc = 0; last_rise = 0; per_bad = 0;
    mosi_bits = 8'h00; rx_got = 8'hAA; prev = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      if (c == 1) begin
        b_tx_valid = 1'b0;
        b_tx_data  = 8'h00;
      end
      if (!b_spi_csn) csn_low++;
      if (b_spi_clk && !prev) begin
        if (rises > 0 && c - last_rise != 2) per_bad++;
        last_rise = c;
        rises++;
        mosi_bits = {mosi_bits[6:0], b_spi_mosi};
      end
      prev = b_spi_clk;
      if (b_rx_valid) begin
        rxv_cyc = c;
        rx_got  = b_rx_data;
      end
    end
    check("div1_rises", rises, 8);
    check("div1_period_bad", per_bad, 0);
    check("div1_csn_low", csn_low, 17);
    check("div1_rxv_cyc", rxv_cyc, 18);
    check("div1_rx", rx_got, 8'h00);
    check("div1_mosi", mosi_bits, 8'hFF);

    check("sclk_only_with_cs", clk_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
